// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: picks a requester in IDLE,
// latches its byte, then sends start, LSB-first data and stop bits on baudTick.
//
// state | meaning
// IDLE  | line high, arbitrating; no grant in the frameDone cycle
// START | start bit (low), waiting for baudTick
// DATA  | shifting out DATA_WIDTH bits, one per baudTick
// STOP  | stop bit(s) (high), frameDone on the last tick
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baudTick,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic [$clog2(NUM_REQ)-1:0]    grantId,
  output logic                          tx,
  output logic                          busy,
  output logic                          frameDone
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_stop_cnt, w_stop_cnt_nxt;
  logic [ID_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]       r_grant_id, w_grant_id_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_frame_done, w_frame_done_nxt;

  logic                  w_grant_hit;
  logic [ID_W-1:0]       w_grant;
  logic [ID_W:0]         w_sum;
  logic [ID_W-1:0]       w_ptr_inc;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Search upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    w_grant_hit = 1'b0;
    w_grant     = '0;
    w_sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      if (!w_grant_hit && reqValid[w_sum[ID_W-1:0]]) begin
        w_grant_hit = 1'b1;
        w_grant     = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) w_sel_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_ptr_inc = (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + ID_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_stop_cnt_nxt   = r_stop_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_grant_id_nxt   = r_grant_id;
    w_tx_nxt         = r_tx;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    reqReady         = '0;
    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (w_grant_hit && !r_frame_done && !reset) begin
          reqReady[w_grant] = 1'b1;
          w_state_nxt       = START;
          w_shift_nxt       = w_sel_data;
          w_grant_id_nxt    = w_grant;
          w_rr_ptr_nxt      = w_ptr_inc;
          w_bit_cnt_nxt     = '0;
          w_stop_cnt_nxt    = 1'b0;
          w_tx_nxt          = 1'b0;
          w_busy_nxt        = 1'b1;
        end
      end
      START: begin
        if (baudTick) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end
      DATA: begin
        if (baudTick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
            w_state_nxt    = STOP;
            w_stop_cnt_nxt = 1'b0;
            w_tx_nxt       = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      STOP: begin
        w_tx_nxt = 1'b1;
        if (baudTick) begin
          if (r_stop_cnt == 1'(STOP_BITS-1)) begin
            w_state_nxt      = IDLE;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign grantId   = r_grant_id;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign frameDone = r_frame_done;

endmodule
